bicubic_accum: RTL and testbench
================================

Name: bicubic_accum

Overview:
- Consumer end of the bicubic multiplier interface.
- Accepts a stream of sign-magnitude tap products (8-bit magnitude plus sign bit, already scaled by >>7) over a valid/ready handshake.
- Sums TAPS consecutive products in a two's-complement accumulator, clamps the total to 0..255, and presents one interpolated pixel per TAPS inputs on an output valid/ready handshake.
- Sits between the bank of product generators and the upscaled-pixel writer.

Parameters:
- TAPS, 16, number of products summed per output pixel (4x4 bicubic window); legal range 2..64.
- ACC_W, 16, signed accumulator width; must satisfy 2^(ACC_W-1) > TAPS*255.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  product sample valid.
- in_ready  output  1  block can accept a product this cycle.
- in_product  input  8  product magnitude.
- in_product_sign  input  1  1 = negative.
- out_valid  output  1  out_pixel holds a result.
- out_ready  input  1  downstream accepts the result.
- out_pixel  output  8  clamped interpolated pixel.
- out_clipped  output  1  result was clamped (sum <0 or >255).
- tap_idx  output  clog2(TAPS)  index of the next tap to be accepted (debug/alignment).

Behaviour:
- Reset (async, immediate):
  - acc=0, tap_cnt=0, out_valid=0, out_pixel=0, out_clipped=0.
  - in_ready follows its combinational equation with out_valid=0, so it is 1 during and after reset.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Sign-magnitude to two's complement:
  - term = sign ? -{0,mag} : {0,mag}, zero-extended to ACC_W before negation.
  - Magnitude 0 with sign 1 contributes 0.
- Non-last tap accepted (tap_cnt < TAPS-1): acc <= acc + term; tap_cnt++. Not affected by output stalls.
- Last tap accepted (tap_cnt == TAPS-1):
  - sum = acc + term.
  - out_pixel <= clamp(sum): sum<0 -> 0; sum>255 -> 255; otherwise sum[7:0].
  - out_clipped <= (sum<0) || (sum>255).
  - out_valid <= 1; acc <= 0; tap_cnt <= 0.
- Latency: result is valid the cycle after the last tap transfer. Throughput: one input per cycle, sustained.
- in_ready = ~(tap_cnt==TAPS-1 && out_valid && ~out_ready). Only the last tap is held off while a previous result is unconsumed.
- Output register:
  - out_valid clears on an output transfer, unless a last-tap input transfer occurs in the same cycle; then it stays 1 with the new data.
  - out_pixel and out_clipped are stable while out_valid && ~out_ready.
- Accumulator never overflows given the ACC_W constraint; no wrap handling is required.
- Between input transfers, acc and tap_cnt hold. in_valid may drop mid-window with no loss.
- Reset mid-window discards the partial sum and any pending output; the next accepted product is tap 0.
- Clamp is applied only to the final sum, never to intermediate partial sums. Partial sums may go negative or exceed 255.

Test Plan:
- 16 products of magnitude 16, all positive, out_ready=1 -> one out_valid pulse a cycle after the 16th transfer; out_pixel=255, out_clipped=1. With magnitude 15 -> 240, out_clipped=0.
- Signed mix: taps 0..15 = +100,-3,+50,-20, then 12 zeros (including one -0) -> out_pixel=127, out_clipped=0. Same window with tap1=-230 -> sum=-100 -> out_pixel=0, out_clipped=1.
- Backpressure: out_ready=0 after first result, second window streamed continuously -> taps 0..14 accepted, in_ready=0 at tap 15. First result held stable. Raise out_ready -> first result transfers, tap 15 is accepted the same cycle, second result appears next cycle.
- Gapped input: in_valid toggled randomly across 3 windows with random signed products -> each out_pixel equals the reference model clamp(sum). tap_idx wraps 15->0 at each last tap.
- Async reset asserted after tap 7 with out_valid=1 -> outputs clear immediately (out_valid=0, tap_idx=0). A subsequent full window of +8 x16 yields 128.
- TAPS=4, ACC_W=12 build: taps +255,+255,-1,0 -> out_pixel=255, out_clipped=1, result one cycle after the 4th transfer.

Source files
------------

// File: rtl/bicubic_accum.sv
// Bicubic tap accumulator: sums TAPS sign-magnitude products, clamps the
// total to 0..255 and presents one pixel per window on a valid/ready output.
module bicubic_accum #(
    parameter int TAPS  = 16,
    parameter int ACC_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_product,
    input  logic                     in_product_sign,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_pixel,
    output logic                     out_clipped,
    output logic [$clog2(TAPS)-1:0]  tap_idx
);

    localparam int CW = $clog2(TAPS);
    localparam logic [CW-1:0]           LAST_TAP = CW'(TAPS - 1);
    localparam logic signed [ACC_W-1:0] MAX_PIX  = ACC_W'(255);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] mag_ext;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] sum;
    logic [CW-1:0]           tap_cnt;
    logic                    last_tap;
    logic                    in_xfer;
    logic                    out_xfer;
    logic                    sum_neg;
    logic                    sum_big;
    logic [7:0]              clamped;

    // Only the closing tap of a window is held off while the previous
    // result is still waiting; earlier taps keep streaming.
    assign last_tap = (tap_cnt == LAST_TAP);
    assign in_ready = ~(last_tap & out_valid & ~out_ready);
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;
    assign tap_idx  = tap_cnt;

    // Sign-magnitude to two's complement, running sum and final clamp
    always_comb begin
        mag_ext = {{(ACC_W-8){1'b0}}, in_product};
        term    = in_product_sign ? -mag_ext : mag_ext;
        sum     = acc + term;
        sum_neg = sum[ACC_W-1];
        sum_big = ~sum_neg & (sum > MAX_PIX);
        if (sum_neg) begin
            clamped = 8'd0;
        end else if (sum_big) begin
            clamped = 8'd255;
        end else begin
            clamped = sum[7:0];
        end
    end

    // Accumulator and tap counter advance on every accepted product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            tap_cnt <= '0;
        end else if (in_xfer) begin
            if (last_tap) begin
                acc     <= '0;
                tap_cnt <= '0;
            end else begin
                acc     <= sum;
                tap_cnt <= tap_cnt + CW'(1);
            end
        end
    end

    // Output register: loads on the closing tap, clears when consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_pixel   <= 8'd0;
            out_clipped <= 1'b0;
        end else if (in_xfer && last_tap) begin
            out_valid   <= 1'b1;
            out_pixel   <= clamped;
            out_clipped <= sum_neg | sum_big;
        end else if (out_xfer) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bicubic_accum.sv
// Self-checking bench for bicubic_accum: vector table, backpressure and
// reset sequences, randomized gapped windows against a sum/clamp model,
// and a small TAPS=4 build.
module tb_bicubic_accum;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_product;
    logic       in_product_sign;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_pixel;
    logic       out_clipped;
    logic [3:0] tap_idx;

    logic       in_valid4;
    logic       in_ready4;
    logic [7:0] in_product4;
    logic       in_sign4;
    logic       out_valid4;
    logic       out_ready4;
    logic [7:0] out_pixel4;
    logic       out_clipped4;
    logic [1:0] tap_idx4;

    int tests = 0;
    int fails = 0;

    bicubic_accum #(.TAPS(16), .ACC_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_product(in_product), .in_product_sign(in_product_sign),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pixel(out_pixel), .out_clipped(out_clipped),
        .tap_idx(tap_idx)
    );

    bicubic_accum #(.TAPS(4), .ACC_W(12)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .in_product(in_product4), .in_product_sign(in_sign4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_pixel(out_pixel4), .out_clipped(out_clipped4),
        .tap_idx(tap_idx4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (window sum + clamp) ----------------
    int win_q[$];
    int exp_pix_q[$];
    int exp_clip_q[$];

    function automatic int clamp_pix(input int s);
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            win_q.delete();
            exp_pix_q.delete();
            exp_clip_q.delete();
        end else begin
            check("sb_tap_idx", int'(tap_idx), win_q.size());
            if (out_valid && out_ready) begin
                if (exp_pix_q.size() == 0) begin
                    check("sb_unexpected_out", 1, 0);
                end else begin
                    check("sb_pixel", int'(out_pixel), exp_pix_q.pop_front());
                    check("sb_clipped", int'(out_clipped), exp_clip_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                win_q.push_back(in_product_sign ? -int'(in_product) : int'(in_product));
                if (win_q.size() == 16) begin
                    int s;
                    s = 0;
                    foreach (win_q[k]) s += win_q[k];
                    exp_pix_q.push_back(clamp_pix(s));
                    exp_clip_q.push_back((s < 0 || s > 255) ? 1 : 0);
                    win_q.delete();
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called just after a rising edge; returns just after the edge that
    // accepted the product. Persistent stall raises out_ready to unblock.
    task automatic feed_tap(input logic [7:0] m, input logic s, output int waited);
        waited = 0;
        in_valid        = 1'b1;
        in_product      = m;
        in_product_sign = s;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            @(posedge clk); #1;
            waited++;
            if (waited == 3) out_ready = 1'b1;
            if (waited > 50) begin
                check("feed_timeout", waited, 0);
                return;
            end
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        string           name;
        logic [15:0][7:0] mag;
        logic [15:0]     sgn;
        int              pix;
        int              clip;
    } vec_t;

    vec_t vecs[10];

    task automatic run_window(input vec_t v);
        int w;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check({v.name, "_early_valid"}, int'(out_valid), 0);
            feed_tap(v.mag[i], v.sgn[i], w);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check({v.name, "_valid"}, int'(out_valid), 1);
        check({v.name, "_pixel"}, int'(out_pixel), v.pix);
        check({v.name, "_clipped"}, int'(out_clipped), v.clip);
        @(posedge clk); #1;
        @(negedge clk);
        check({v.name, "_pulse_end"}, int'(out_valid), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int w;
        for (int n = 0; n < 10; n++) begin
            vecs[n].mag = '0;
            vecs[n].sgn = '0;
        end
        vecs[0].name = "all16";
        for (int i = 0; i < 16; i++) vecs[0].mag[i] = 8'd16;
        vecs[0].pix = 255; vecs[0].clip = 1;
        vecs[1].name = "all15";
        for (int i = 0; i < 16; i++) vecs[1].mag[i] = 8'd15;
        vecs[1].pix = 240; vecs[1].clip = 0;
        vecs[2].name = "mix127";
        vecs[2].mag[0] = 8'd100; vecs[2].mag[1] = 8'd3; vecs[2].sgn[1] = 1'b1;
        vecs[2].mag[2] = 8'd50;  vecs[2].mag[3] = 8'd20; vecs[2].sgn[3] = 1'b1;
        vecs[2].sgn[9] = 1'b1;
        vecs[2].pix = 127; vecs[2].clip = 0;
        vecs[3] = vecs[2];
        vecs[3].name = "mixneg";
        vecs[3].mag[1] = 8'd230;
        vecs[3].pix = 0; vecs[3].clip = 1;
        vecs[4].name = "all8";
        for (int i = 0; i < 16; i++) vecs[4].mag[i] = 8'd8;
        vecs[4].pix = 128; vecs[4].clip = 0;
        vecs[5].name = "exact255";
        vecs[5].mag[0] = 8'd255;
        vecs[5].pix = 255; vecs[5].clip = 0;
        vecs[6].name = "sum256";
        vecs[6].mag[0] = 8'd255; vecs[6].mag[15] = 8'd1;
        vecs[6].pix = 255; vecs[6].clip = 1;
        vecs[7].name = "zero";
        vecs[7].mag[4] = 8'd5; vecs[7].mag[12] = 8'd5; vecs[7].sgn[12] = 1'b1;
        vecs[7].pix = 0; vecs[7].clip = 0;
        vecs[8].name = "minus1";
        vecs[8].mag[15] = 8'd1; vecs[8].sgn[15] = 1'b1;
        vecs[8].pix = 0; vecs[8].clip = 1;
        vecs[9].name = "neg_partial";
        vecs[9].mag[0] = 8'd200; vecs[9].sgn[0] = 1'b1;
        vecs[9].mag[1] = 8'd200; vecs[9].sgn[1] = 1'b1;
        vecs[9].mag[14] = 8'd255; vecs[9].mag[15] = 8'd200;
        vecs[9].pix = 55; vecs[9].clip = 0;

        rst = 1'b1;
        in_valid = 1'b0; in_product = '0; in_product_sign = 1'b0; out_ready = 1'b1;
        in_valid4 = 1'b0; in_product4 = '0; in_sign4 = 1'b0; out_ready4 = 1'b1;
        #3;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_pixel", int'(out_pixel), 0);
        check("rst_out_clipped", int'(out_clipped), 0);
        check("rst_tap_idx", int'(tap_idx), 0);
        check("rst_in_ready", int'(in_ready), 1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven windows with out_ready held high
        for (int n = 0; n < 10; n++) run_window(vecs[n]);

        // Backpressure: result A held while window B streams up to tap 15
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) feed_tap(vecs[2].mag[i], vecs[2].sgn[i], w);
        for (int i = 0; i < 15; i++) begin
            feed_tap(8'd16, 1'b0, w);
            check("bp_tap_stall", w, 0);
        end
        in_valid = 1'b1; in_product = 8'd16; in_product_sign = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("bp_in_ready_low", int'(in_ready), 0);
            check("bp_hold_valid", int'(out_valid), 1);
            check("bp_hold_pixel", int'(out_pixel), 127);
            check("bp_hold_clipped", int'(out_clipped), 0);
            check("bp_tap_idx", int'(tap_idx), 15);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_high", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_b_valid", int'(out_valid), 1);
        check("bp_b_pixel", int'(out_pixel), 255);
        check("bp_b_clipped", int'(out_clipped), 1);
        check("bp_b_tap_idx", int'(tap_idx), 0);
        @(posedge clk); #1;

        // Async reset mid-window with a result pending
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) feed_tap(8'd20, 1'b0, w);
        for (int i = 0; i < 8; i++) feed_tap(8'd9, 1'b0, w);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("ar_out_valid", int'(out_valid), 0);
        check("ar_tap_idx", int'(tap_idx), 0);
        check("ar_out_pixel", int'(out_pixel), 0);
        check("ar_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        run_window(vecs[4]);

        // Randomized gapped windows with occasional output stalls
        for (int win = 0; win < 3; win++) begin
            for (int i = 0; i < 16; i++) begin
                int gap;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
                out_ready = ($urandom_range(0, 3) != 0);
                feed_tap(8'($urandom_range(0, 80)), 1'($urandom_range(0, 1)), w);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rand_drained", exp_pix_q.size(), 0);

        // TAPS=4 build: 255 + 255 - 1 + 0
        for (int i = 0; i < 4; i++) begin
            in_valid4 = 1'b1;
            in_product4 = (i < 2) ? 8'd255 : ((i == 2) ? 8'd1 : 8'd0);
            in_sign4 = (i == 2);
            @(negedge clk);
            check("t4_in_ready", int'(in_ready4), 1);
            check("t4_tap_idx", int'(tap_idx4), i);
            check("t4_early_valid", int'(out_valid4), 0);
            @(posedge clk); #1;
        end
        in_valid4 = 1'b0;
        @(negedge clk);
        check("t4_valid", int'(out_valid4), 1);
        check("t4_pixel", int'(out_pixel4), 255);
        check("t4_clipped", int'(out_clipped4), 1);
        check("t4_tap_wrap", int'(tap_idx4), 0);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
